// File: rtl/recip_lookup_ctrl.sv
// recip_lookup_ctrl: serves divisor requests from a direct-mapped reciprocal cache, refilling it on a miss
// with one clear/valid/wait reciprocal-unit transaction. Define RECIP_STATS_EN to add saturating hit/miss/error counters.
module recip_lookup_ctrl #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned TIMEOUT_CYC = 1023,
   parameter logic [31:0] ERR_VALUE   = 32'hFFFF_FFFF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   input  logic [7:0]  i_req_divisor,
   output logic        o_req_ready,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_quotient,
   output logic        o_rsp_err,
   output logic        o_recip_clear,
   output logic        o_recip_valid,
   output logic [7:0]  o_recip_divisor,
   input  logic        i_recip_valid,
   input  logic [31:0] i_recip_quotient
`ifdef RECIP_STATS_EN
   ,
   output logic [15:0] o_hit_cnt,
   output logic [15:0] o_miss_cnt,
   output logic [15:0] o_err_cnt
`endif
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned TAG_W = 8 - IDX_W;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_CLEAR,
      S_WAIT,
      S_RESP
   } state_t;

   state_t             state, state_nxt;
   logic [7:0]         div_q, div_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;

   logic [DEPTH-1:0]   cache_vld;
   logic [TAG_W-1:0]   cache_tag  [DEPTH];
   logic [31:0]        cache_data [DEPTH];

   logic [IDX_W-1:0]   idx_c;
   logic [TAG_W-1:0]   tag_c;
   logic               hit_c;
   logic               fill_c;

   logic               req_ready_nxt;
   logic               rsp_valid_nxt;
   logic [31:0]        quot_nxt;
   logic               err_nxt;
   logic               clear_nxt;
   logic               recip_valid_nxt;
   logic [7:0]         recip_div_nxt;

   assign idx_c = div_q[IDX_W-1:0];
   assign tag_c = div_q[7:IDX_W];
   assign hit_c = cache_vld[idx_c] && (cache_tag[idx_c] == tag_c);

   // Next-state and next-output logic; outputs are registered from the next state.
   always_comb begin
      state_nxt = state;
      div_nxt   = div_q;
      cnt_nxt   = cnt;
      quot_nxt  = o_rsp_quotient;
      err_nxt   = o_rsp_err;
      fill_c    = 1'b0;

      case (state)
         S_IDLE: begin
            if (i_req_valid) begin
               div_nxt   = i_req_divisor;
               state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (div_q == 8'd0) begin
               quot_nxt  = ERR_VALUE;
               err_nxt   = 1'b1;
               state_nxt = S_RESP;
            end else if (hit_c) begin
               quot_nxt  = cache_data[idx_c];
               err_nxt   = 1'b0;
               state_nxt = S_RESP;
            end else begin
               state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            cnt_nxt   = '0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            cnt_nxt = CNT_W'(cnt + 1'b1);
            // A result arriving on the timeout cycle still wins.
            if (i_recip_valid) begin
               quot_nxt  = i_recip_quotient;
               err_nxt   = 1'b0;
               fill_c    = 1'b1;
               state_nxt = S_RESP;
            end else if (cnt_nxt == CNT_W'(TIMEOUT_CYC)) begin
               quot_nxt  = ERR_VALUE;
               err_nxt   = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      req_ready_nxt   = (state_nxt == S_IDLE);
      rsp_valid_nxt   = (state_nxt == S_RESP);
      clear_nxt       = (state_nxt == S_CLEAR);
      recip_valid_nxt = (state_nxt == S_WAIT);
      recip_div_nxt   = (state_nxt == S_WAIT) ? div_nxt : 8'd0;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state           <= S_IDLE;
         div_q           <= 8'd0;
         cnt             <= '0;
         cache_vld       <= '0;
         o_req_ready     <= 1'b1;
         o_rsp_valid     <= 1'b0;
         o_rsp_quotient  <= 32'd0;
         o_rsp_err       <= 1'b0;
         o_recip_clear   <= 1'b0;
         o_recip_valid   <= 1'b0;
         o_recip_divisor <= 8'd0;
      end else begin
         state           <= state_nxt;
         div_q           <= div_nxt;
         cnt             <= cnt_nxt;
         o_req_ready     <= req_ready_nxt;
         o_rsp_valid     <= rsp_valid_nxt;
         o_rsp_quotient  <= quot_nxt;
         o_rsp_err       <= err_nxt;
         o_recip_clear   <= clear_nxt;
         o_recip_valid   <= recip_valid_nxt;
         o_recip_divisor <= recip_div_nxt;
         if (fill_c) begin
            cache_vld[idx_c] <= 1'b1;
         end
      end
   end

   // Tag/data storage needs no reset; the valid bits qualify it.
   always_ff @(posedge i_clk) begin
      if (fill_c && !i_reset) begin
         cache_tag[idx_c]  <= tag_c;
         cache_data[idx_c] <= i_recip_quotient;
      end
   end

`ifdef RECIP_STATS_EN
   logic hit_ev_c;
   logic miss_ev_c;
   logic err_ev_c;

   assign hit_ev_c  = (state == S_CHECK) && (div_q != 8'd0) && hit_c;
   assign miss_ev_c = (state == S_CHECK) && (div_q != 8'd0) && !hit_c;
   assign err_ev_c  = (state != S_RESP) && (state_nxt == S_RESP) && err_nxt;

   // Saturating outcome counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_hit_cnt  <= 16'd0;
         o_miss_cnt <= 16'd0;
         o_err_cnt  <= 16'd0;
      end else begin
         if (hit_ev_c && (o_hit_cnt != 16'hFFFF)) begin
            o_hit_cnt <= o_hit_cnt + 16'd1;
         end
         if (miss_ev_c && (o_miss_cnt != 16'hFFFF)) begin
            o_miss_cnt <= o_miss_cnt + 16'd1;
         end
         if (err_ev_c && (o_err_cnt != 16'hFFFF)) begin
            o_err_cnt <= o_err_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_recip_lookup_ctrl.sv
// Scoreboard bench for recip_lookup_ctrl: stimulus pushes expected responses, a monitor pops and compares them.
module tb_recip_lookup_ctrl;

   logic        clk;
   logic        i_reset;
   logic        i_req_valid;
   logic [7:0]  i_req_divisor;
   logic        o_req_ready;
   logic        o_rsp_valid;
   logic [31:0] o_rsp_quotient;
   logic        o_rsp_err;
   logic        o_recip_clear;
   logic        o_recip_valid;
   logic [7:0]  o_recip_divisor;
   logic        i_recip_valid;
   logic [31:0] i_recip_quotient;
`ifdef RECIP_STATS_EN
   logic [15:0] o_hit_cnt;
   logic [15:0] o_miss_cnt;
   logic [15:0] o_err_cnt;
`endif

   recip_lookup_ctrl dut (
      .i_clk            (clk),
      .i_reset          (i_reset),
      .i_req_valid      (i_req_valid),
      .i_req_divisor    (i_req_divisor),
      .o_req_ready      (o_req_ready),
      .o_rsp_valid      (o_rsp_valid),
      .o_rsp_quotient   (o_rsp_quotient),
      .o_rsp_err        (o_rsp_err),
      .o_recip_clear    (o_recip_clear),
      .o_recip_valid    (o_recip_valid),
      .o_recip_divisor  (o_recip_divisor),
      .i_recip_valid    (i_recip_valid),
      .i_recip_quotient (i_recip_quotient)
`ifdef RECIP_STATS_EN
      ,
      .o_hit_cnt        (o_hit_cnt),
      .o_miss_cnt       (o_miss_cnt),
      .o_err_cnt        (o_err_cnt)
`endif
   );

   typedef struct packed {
      logic [31:0] q;
      logic        e;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] exp_div;
   int         total = 0;
   int         bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: response scoreboard and divisor stability while waiting.
   always @(negedge clk) begin
      if (o_rsp_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got quotient %h err %0d expected no response", o_rsp_quotient, o_rsp_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_quotient", o_rsp_quotient, e.q);
            check("rsp_err", 32'(o_rsp_err), 32'(e.e));
         end
      end
      if (o_recip_valid) begin
         check("recip_divisor", 32'(o_recip_divisor), 32'(exp_div));
      end
   end

   // One request; the reciprocal model answers on the delay-th o_recip_valid cycle (delay<=0: never).
   task automatic run_req(input logic [7:0] div, input int delay, input logic [31:0] model_q,
                          input logic [31:0] eq, input logic ee,
                          input int exp_lat, input int exp_clr, input int exp_wait);
      exp_t t;
      int   lat;
      int   clr;
      int   wcyc;
      bit   done;
      t.q = eq;
      t.e = ee;
      exp_q.push_back(t);
      exp_div = div;
      @(negedge clk);
      check("req_ready", 32'(o_req_ready), 32'd1);
      i_req_valid   = 1'b1;
      i_req_divisor = div;
      lat  = 0;
      clr  = 0;
      wcyc = 0;
      done = 1'b0;
      while (!done && lat < 3000) begin
         @(negedge clk);
         i_req_valid   = 1'b0;
         i_recip_valid = 1'b0;
         lat++;
         if (o_recip_clear) clr++;
         if (o_recip_valid) begin
            wcyc++;
            if (delay > 0 && wcyc == delay) begin
               i_recip_valid    = 1'b1;
               i_recip_quotient = model_q;
            end
         end
         if (o_rsp_valid) done = 1'b1;
      end
      check("rsp_seen", 32'(done), 32'd1);
      check("latency", lat, exp_lat);
      check("clear_pulses", clr, exp_clr);
      check("wait_cycles", wcyc, exp_wait);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset          = 1'b1;
      i_req_valid      = 1'b0;
      i_req_divisor    = 8'd0;
      i_recip_valid    = 1'b0;
      i_recip_quotient = 32'd0;
      exp_div          = 8'd0;
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      check("reset_ready", 32'(o_req_ready), 32'd1);
      check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("reset_quotient", o_rsp_quotient, 32'd0);
      check("reset_err", 32'(o_rsp_err), 32'd0);
      check("reset_clear", 32'(o_recip_clear), 32'd0);
      check("reset_recip_valid", 32'(o_recip_valid), 32'd0);
      check("reset_recip_div", 32'(o_recip_divisor), 32'd0);

      // Miss, then hit on the same divisor
      run_req(8'd3, 20, 32'h5555_5555, 32'h5555_5555, 1'b0, 23, 1, 20);
      run_req(8'd3, -1, 32'h0, 32'h5555_5555, 1'b0, 2, 0, 0);
      // Index conflict: 11 evicts 3, then 3 evicts 11
      run_req(8'd11, 5, 32'h1745_D174, 32'h1745_D174, 1'b0, 8, 1, 5);
      run_req(8'd3, 3, 32'h5555_5555, 32'h5555_5555, 1'b0, 6, 1, 3);
      // Zero divisor
      run_req(8'd0, -1, 32'h0, 32'hFFFF_FFFF, 1'b1, 2, 0, 0);
      // Timeout, not cached; then a real result fills and hits
      run_req(8'd7, -1, 32'h0, 32'hFFFF_FFFF, 1'b1, 1026, 1, 1023);
      run_req(8'd7, 2, 32'h2492_4924, 32'h2492_4924, 1'b0, 5, 1, 2);
      run_req(8'd7, -1, 32'h0, 32'h2492_4924, 1'b0, 2, 0, 0);
      // Result on the timeout cycle wins
      run_req(8'd9, 1023, 32'h1C71_C71C, 32'h1C71_C71C, 1'b0, 1026, 1, 1023);

      // Reset during WAIT for divisor 5
      begin
         int  n;
         bit  seen;
         exp_div = 8'd5;
         @(negedge clk);
         i_req_valid   = 1'b1;
         i_req_divisor = 8'd5;
         n    = 0;
         seen = 1'b0;
         while (!seen && n < 50) begin
            @(negedge clk);
            i_req_valid = 1'b0;
            n++;
            if (o_recip_valid) seen = 1'b1;
         end
         check("mid_wait_reached", 32'(seen), 32'd1);
         repeat (4) @(negedge clk);
         i_reset = 1'b1;
         @(negedge clk);
         i_reset = 1'b0;
         check("mid_rst_ready", 32'(o_req_ready), 32'd1);
         check("mid_rst_recip_valid", 32'(o_recip_valid), 32'd0);
         check("mid_rst_clear", 32'(o_recip_clear), 32'd0);
         check("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
         i_recip_valid    = 1'b1;
         i_recip_quotient = 32'hDEAD_BEEF;
         repeat (3) begin
            @(negedge clk);
            check("late_valid_rsp", 32'(o_rsp_valid), 32'd0);
            check("late_valid_ready", 32'(o_req_ready), 32'd1);
         end
         i_recip_valid = 1'b0;
      end
      run_req(8'd3, 4, 32'h5555_5555, 32'h5555_5555, 1'b0, 7, 1, 4);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
